// File: rtl/stream_rr_arbiter_if.sv
// stream_rr_arbiter_if: requester-side and sink-side signals of the round-robin stream arbiter
interface stream_rr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ*DATA_WIDTH-1:0] in_data;
  logic [NUM_REQ-1:0]            in_valid;
  logic [NUM_REQ-1:0]            in_last;
  logic [NUM_REQ-1:0]            in_ready;
  logic [DATA_WIDTH-1:0]         dout;
  logic                          out_valid;
  logic                          out_last;
  logic                          next_ready;
  logic [$clog2(NUM_REQ)-1:0]    grant_id;
  logic                          busy;
  modport master (
    output in_data, in_valid, in_last, next_ready,
    input  in_ready, dout, out_valid, out_last, grant_id, busy
  );
  modport slave (
    input  in_data, in_valid, in_last, next_ready,
    output in_ready, dout, out_valid, out_last, grant_id, busy
  );
endinterface

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: packet-granular round-robin arbiter sharing one valid/ready sink among NUM_REQ requesters
module stream_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 0
) (
  input logic               clk,
  input logic               rst_n,
  stream_rr_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = MAX_BURST == 0 ? 1 : $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t        state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, grant_id_q, grant_id_d, off, pick;
  logic [IW:0]   sum;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0] rot;
  logic          busy, accept, burst_end;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  // Rotate requests so bit 0 is rr_ptr, take the lowest set bit, then rotate the index back.
  always_comb begin
    rot = NUM_REQ'({bus.in_valid, bus.in_valid} >> rr_ptr_q);
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (rot[k]) off = IW'(k);
    sum  = {1'b0, rr_ptr_q} + {1'b0, off};
    pick = sum >= (IW+1)'(NUM_REQ) ? IW'(sum - (IW+1)'(NUM_REQ)) : sum[IW-1:0];
  end
  assign busy          = state_q == BUSY;
  assign bus.busy      = busy;
  assign bus.grant_id  = grant_id_q;
  assign bus.out_valid = busy && bus.in_valid[grant_id_q];
  assign bus.dout      = bus.in_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
  assign bus.in_ready  = (busy && bus.next_ready) ? NUM_REQ'(1) << grant_id_q : '0;
  assign burst_end     = (MAX_BURST != 0) && (beat_cnt_q == CW'(MAX_BURST - 1));
  assign bus.out_last  = bus.out_valid && (bus.in_last[grant_id_q] || burst_end);
  assign accept        = bus.out_valid && bus.next_ready;
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    if (!busy) begin
      if (|bus.in_valid) begin
        state_d    = BUSY;
        grant_id_d = pick;
        beat_cnt_d = '0;
      end
    end else if (accept) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
      if (bus.out_last) begin
        state_d  = IDLE;
        rr_ptr_d = grant_id_q == IW'(NUM_REQ - 1) ? '0 : grant_id_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter: directed packets with a queue scoreboard of expected accepted beats
module tb_stream_rr_arbiter;
  localparam int N = 4, W = 8;
  typedef struct packed {logic [1:0] g; logic [W-1:0] d; logic l;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int vectors = 0, miscompares = 0;
  logic [W:0] srcq [N][$];
  logic [N-1:0] en = '1, took = '0;
  exp_t expq [$];
  always #5 clk = ~clk;
  stream_rr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(W)) bus ();
  stream_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .MAX_BURST(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
    end
  endtask
  task automatic src(input int r, input logic [W-1:0] d, input logic l);
    srcq[r].push_back({l, d});
  endtask
  task automatic ex(input logic [1:0] g, input logic [W-1:0] d, input logic l);
    expq.push_back('{g: g, d: d, l: l});
  endtask
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      logic [W:0] h;
      h = srcq[i].size() > 0 ? srcq[i][0] : '0;
      bus.in_valid[i]       = en[i] && srcq[i].size() > 0;
      bus.in_last[i]        = h[W];
      bus.in_data[i*W +: W] = h[W-1:0];
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (took[i]) void'(srcq[i].pop_front());
    drive();
    #2;
  endtask
  task automatic wait_q(input int n, input string nm);
    int t = 0;
    while (expq.size() > n && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) chk({nm, "_timeout"}, expq.size(), n);
  endtask
  always @(negedge clk) took <= bus.in_valid & bus.in_ready;
  always @(negedge clk) if (rst_n) begin
    exp_t e;
    chk("in_ready_onehot0", 32'($onehot0(bus.in_ready)), 1);
    if (bus.out_valid && bus.next_ready) begin
      if (expq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL extra_beat: got grant %0d data %0h, expected no beat", bus.grant_id, bus.dout);
      end else begin
        e = expq.pop_front();
        chk("beat_grant", bus.grant_id, e.g);
        chk("beat_data", bus.dout, e.d);
        chk("beat_last", bus.out_last, e.l);
      end
    end
  end
  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int cnt;
    bus.next_ready = 1'b1;
    drive();
    bus.in_valid = '1;
    #3;
    chk("rst_busy", bus.busy, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_grant_id", bus.grant_id, 0);
    drive();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    // single requester, 3-beat packet
    src(2, 8'hA1, 0); src(2, 8'hA2, 0); src(2, 8'hA3, 1);
    ex(2, 8'hA1, 0); ex(2, 8'hA2, 0); ex(2, 8'hA3, 1);
    drive();
    tick();
    chk("t1_busy", bus.busy, 1);
    chk("t1_grant", bus.grant_id, 2);
    wait_q(0, "t1");
    chk("t1_idle", bus.busy, 0);
    // fairness: rr_ptr is 3 after the previous grant
    for (int i = 0; i < N; i++) begin
      src(i, 8'(8'h10 * i), 1);
      src(i, 8'(8'h10 * i + 1), 1);
    end
    ex(3, 8'h30, 1); ex(0, 8'h00, 1); ex(1, 8'h10, 1); ex(2, 8'h20, 1);
    ex(3, 8'h31, 1); ex(0, 8'h01, 1); ex(1, 8'h11, 1); ex(2, 8'h21, 1);
    drive();
    cnt = 0;
    while (expq.size() > 0 && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("t2_cycles", cnt, 16);
    // backpressure mid-packet
    src(1, 8'hB1, 0); src(1, 8'hB2, 0); src(1, 8'hB3, 1);
    ex(1, 8'hB1, 0); ex(1, 8'hB2, 0); ex(1, 8'hB3, 1);
    drive();
    wait_q(2, "t3a");
    bus.next_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t3_in_ready", bus.in_ready[1], 0);
      chk("t3_out_valid", bus.out_valid, 1);
      chk("t3_dout", bus.dout, 8'hB2);
      chk("t3_out_last", bus.out_last, 0);
    end
    bus.next_ready = 1'b1;
    wait_q(0, "t3b");
    chk("t3_idle", bus.busy, 0);
    // burst limit 4: req0 runs 10 unterminated beats then one with last
    for (int k = 0; k < 11; k++) src(0, 8'(8'hD0 + k), k == 10);
    src(1, 8'hC1, 0); src(1, 8'hC2, 1);
    ex(0, 8'hD0, 0); ex(0, 8'hD1, 0); ex(0, 8'hD2, 0); ex(0, 8'hD3, 1);
    ex(1, 8'hC1, 0); ex(1, 8'hC2, 1);
    ex(0, 8'hD4, 0); ex(0, 8'hD5, 0); ex(0, 8'hD6, 0); ex(0, 8'hD7, 1);
    ex(0, 8'hD8, 0); ex(0, 8'hD9, 0); ex(0, 8'hDA, 1);
    drive();
    wait_q(0, "t4");
    chk("t4_idle", bus.busy, 0);
    // granted req3 stalls while req0 waits
    src(3, 8'hE1, 0); src(3, 8'hE2, 0); src(3, 8'hE3, 1); src(0, 8'hF1, 1);
    ex(3, 8'hE1, 0); ex(3, 8'hE2, 0); ex(3, 8'hE3, 1); ex(0, 8'hF1, 1);
    drive();
    wait_q(3, "t5a");
    en[3] = 1'b0;
    drive();
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t5_out_valid", bus.out_valid, 0);
      chk("t5_grant", bus.grant_id, 3);
      chk("t5_busy", bus.busy, 1);
      chk("t5_req0_ready", bus.in_ready[0], 0);
    end
    en[3] = 1'b1;
    drive();
    wait_q(0, "t5b");
    chk("t5_idle", bus.busy, 0);
    // reset during beat 2 of 4; rr_ptr is 1 beforehand
    src(1, 8'h61, 0); src(1, 8'h62, 0); src(1, 8'h63, 0); src(1, 8'h64, 1);
    ex(1, 8'h61, 0);
    drive();
    wait_q(0, "t6a");
    chk("t6_pre_valid", bus.out_valid, 1);
    chk("t6_pre_dout", bus.dout, 8'h62);
    rst_n = 1'b0;
    #1;
    chk("t6_busy", bus.busy, 0);
    chk("t6_out_valid", bus.out_valid, 0);
    chk("t6_out_last", bus.out_last, 0);
    chk("t6_in_ready", bus.in_ready, 0);
    chk("t6_grant", bus.grant_id, 0);
    for (int i = 0; i < N; i++) srcq[i].delete();
    drive();
    tick();
    rst_n = 1'b1;
    src(0, 8'h4B, 1); src(1, 8'h4C, 1);
    ex(0, 8'h4B, 1); ex(1, 8'h4C, 1);
    drive();
    wait_q(0, "t6b");
    chk("t6_idle", bus.busy, 0);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
